// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: bus-slave byte FIFO feeding a TX-only, MSB-first SPI master.
// The CPU pushes bytes through TXDATA. The block holds spi_start_o high for a
// whole burst, so a multi-byte command goes out under one continuous
// chip-select. spi_data_o always presents the FIFO head.
// Optional feature macro: SPI_TX_IRQ_EN. It adds irq_o, the done sticky bit
// and CTRL.irq_en.
module spi_tx_fifo #(
  parameter int unsigned FifoDepth = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        spi_start_o,
  output logic [7:0]  spi_data_o,
  input  logic        spi_next_req_i
`ifdef SPI_TX_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int unsigned PtrWidth   = $clog2(FifoDepth);
  localparam int unsigned LevelWidth = $clog2(FifoDepth) + 1;
  localparam logic [LevelWidth-1:0] FullLevel = LevelWidth'(FifoDepth);
  localparam logic [LevelWidth-1:0] ZeroLevel = {LevelWidth{1'b0}};
  localparam logic [LevelWidth-1:0] OneLevel  = LevelWidth'(1);
  localparam logic [PtrWidth-1:0]   ZeroPtr   = {PtrWidth{1'b0}};
  localparam logic [PtrWidth-1:0]   OnePtr    = PtrWidth'(1);

  localparam logic [1:0] AddrTxdata = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrCtrl   = 2'd2;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StActive = 1'b1
  } state_e;

  // Zero-extend (or clip) the fill level into the 8-bit STATUS field.
  function automatic logic [7:0] level_to_byte(input logic [LevelWidth-1:0] lvl);
    return 8'(lvl);
  endfunction

  logic [7:0]            mem_r [FifoDepth];
  logic [PtrWidth-1:0]   wr_ptr_r;
  logic [PtrWidth-1:0]   rd_ptr_r;
  logic [LevelWidth-1:0] level_r;
  logic [LevelWidth-1:0] level_s;
  state_e                state_r;
  state_e                state_s;
  logic                  en_r;
  logic                  en_s;
  logic                  overflow_r;
  logic                  overflow_s;
  logic                  rvalid_r;
  logic [31:0]           rdata_r;
  logic [31:0]           rdata_s;

  logic wr_s;
  logic push_req_s;
  logic push_s;
  logic drop_s;
  logic pop_s;
  logic flush_s;
  logic ctrl_wr_s;
  logic stat_wr_s;
  logic full_s;
  logic empty_s;
  logic active_s;
  logic done_bit_s;
  logic irq_en_bit_s;
  logic unused_s;

  // Address bits outside [3:2], the upper write data and the upper byte
  // enables are not decoded.
  assign unused_s = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:8], be_i[3:1]};

  assign full_s   = (level_r == FullLevel);
  assign empty_s  = (level_r == ZeroLevel);
  assign active_s = (state_r == StActive);

  assign wr_s       = req_i && we_i;
  assign push_req_s = wr_s && (addr_i[3:2] == AddrTxdata) && be_i[0];
  assign ctrl_wr_s  = wr_s && (addr_i[3:2] == AddrCtrl) && be_i[0];
  assign stat_wr_s  = wr_s && (addr_i[3:2] == AddrStatus) && be_i[0];
  assign pop_s      = spi_next_req_i && !empty_s;
  // A full FIFO still accepts a byte when the master pops in the same cycle.
  assign push_s     = push_req_s && (!full_s || spi_next_req_i);
  assign drop_s     = push_req_s && full_s && !spi_next_req_i;
  // A flush must not pull the FIFO out from under an active burst.
  assign flush_s    = ctrl_wr_s && wdata_i[1] && !active_s;

  // Next fill level from push/pop/flush.
  always_comb begin
    level_s = level_r;
    if (flush_s) begin
      level_s = ZeroLevel;
    end else begin
      case ({push_s, pop_s})
        2'b10:   level_s = level_r + OneLevel;
        2'b01:   level_s = level_r - OneLevel;
        default: level_s = level_r;
      endcase
    end
  end

  // Burst FSM next state. A burst only ends at a byte boundary (a pop).
  // A start is deferred while a stray pop or a flush is draining the FIFO.
  always_comb begin
    state_s = state_r;
    case (state_r)
      StIdle: begin
        if (en_r && !empty_s && !flush_s && !pop_s) begin
          state_s = StActive;
        end else begin
          state_s = StIdle;
        end
      end
      StActive: begin
        if (pop_s && (!en_r || (level_s == ZeroLevel))) begin
          state_s = StIdle;
        end else begin
          state_s = StActive;
        end
      end
      default: state_s = StIdle;
    endcase
  end

  // Next values of the enable and overflow control bits; a set beats a W1C.
  always_comb begin
    en_s       = en_r;
    overflow_s = overflow_r;
    if (ctrl_wr_s) begin
      en_s = wdata_i[0];
    end else begin
      en_s = en_r;
    end
    if (drop_s) begin
      overflow_s = 1'b1;
    end else if (stat_wr_s && wdata_i[3]) begin
      overflow_s = 1'b0;
    end else begin
      overflow_s = overflow_r;
    end
  end

`ifdef SPI_TX_IRQ_EN
  logic irq_en_r;
  logic irq_en_s;
  logic done_r;
  logic done_s;
  logic irq_r;

  // Next values of the interrupt enable and the done sticky bit.
  always_comb begin
    irq_en_s = irq_en_r;
    done_s   = done_r;
    if (ctrl_wr_s) begin
      irq_en_s = wdata_i[2];
    end else begin
      irq_en_s = irq_en_r;
    end
    if ((state_r == StActive) && (state_s == StIdle)) begin
      done_s = 1'b1;
    end else if (stat_wr_s && wdata_i[4]) begin
      done_s = 1'b0;
    end else begin
      done_s = done_r;
    end
  end

  // Interrupt state registers; irq_o follows done/irq_en on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en_r <= 1'b0;
      done_r   <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      irq_en_r <= irq_en_s;
      done_r   <= done_s;
      irq_r    <= irq_en_s && done_s;
    end
  end

  assign irq_o        = irq_r;
  assign done_bit_s   = done_r;
  assign irq_en_bit_s = irq_en_r;
`else
  assign done_bit_s   = 1'b0;
  assign irq_en_bit_s = 1'b0;
`endif

  // Read mux; reads return the state before this cycle's update.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (req_i && !we_i) begin
      case (addr_i[3:2])
        AddrStatus: rdata_s = {16'h0000, level_to_byte(level_r), 3'b000, done_bit_s,
                               overflow_r, active_s, empty_s, full_s};
        AddrCtrl:   rdata_s = {29'd0, irq_en_bit_s, 1'b0, en_r};
        default:    rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // FIFO storage; cleared on reset so that spi_data_o starts at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wdata_i[7:0];
    end
  end

  // Pointers, level, FSM state and control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r   <= ZeroPtr;
      rd_ptr_r   <= ZeroPtr;
      level_r    <= ZeroLevel;
      state_r    <= StIdle;
      en_r       <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (flush_s) begin
        wr_ptr_r <= ZeroPtr;
        rd_ptr_r <= ZeroPtr;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + OnePtr;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + OnePtr;
        end
      end
      level_r    <= level_s;
      state_r    <= state_s;
      en_r       <= en_s;
      overflow_r <= overflow_s;
    end
  end

  // Bus response: one-cycle rvalid pulse with registered read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
    end else begin
      rvalid_r <= req_i;
      rdata_r  <= rdata_s;
    end
  end

  assign rvalid_o    = rvalid_r;
  assign rdata_o     = rdata_r;
  assign spi_start_o = active_s;
  // The head changes only on a pop, so the master sees a stable byte.
  assign spi_data_o  = mem_r[rd_ptr_r];

endmodule
